// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: grants the single-port data memory to one of two requesters and sequences one access.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default build is round-robin.
module dmem_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic                owner_r;
  logic                owner_nxt_s;
  logic                op_we_r;
  logic                op_we_nxt_s;
  logic [1:0]          gnt_r;
  logic [1:0]          gnt_nxt_s;
  logic [1:0]          done_r;
  logic [1:0]          done_nxt_s;
  logic                busy_r;
  logic [DATA_W-1:0]   rdata0_r;
  logic [DATA_W-1:0]   rdata0_nxt_s;
  logic [DATA_W-1:0]   rdata1_r;
  logic [DATA_W-1:0]   rdata1_nxt_s;
  logic                mem_en_r;
  logic                mem_en_nxt_s;
  logic                mem_we_r;
  logic                mem_we_nxt_s;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [ADDR_W-1:0]   mem_addr_nxt_s;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [DATA_W-1:0]   mem_wdata_nxt_s;

  logic [1:0]          elig_s;
  logic                pick1_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;

  // A requester whose done is showing this cycle is finishing, not asking again.
  assign elig_s      = {req1 & ~done_r[1], req0 & ~done_r[0]};
  assign sel_we_s    = pick1_s ? we1 : we0;
  assign sel_addr_s  = pick1_s ? addr1 : addr0;
  assign sel_wdata_s = pick1_s ? wdata1 : wdata0;

`ifndef ARB_FIXED_PRIO_EN
  logic last_r;

  // Round-robin pointer: last requester to complete; starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (state_r == ST_RESP) begin
      last_r <= owner_r;
    end else begin
      last_r <= last_r;
    end
  end

  assign pick1_s = elig_s[1] & (~elig_s[0] | ~last_r);
`else
  assign pick1_s = elig_s[1] & ~elig_s[0];
`endif

  // Next-state and next-output logic for the IDLE -> ACCESS -> RESP access sequence.
  always_comb begin
    state_nxt_s     = state_r;
    owner_nxt_s     = owner_r;
    op_we_nxt_s     = op_we_r;
    gnt_nxt_s       = gnt_r;
    done_nxt_s      = 2'b00;
    rdata0_nxt_s    = rdata0_r;
    rdata1_nxt_s    = rdata1_r;
    mem_en_nxt_s    = mem_en_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    case (state_r)
      ST_IDLE: begin
        if (elig_s != 2'b00) begin
          state_nxt_s     = ST_ACCESS;
          owner_nxt_s     = pick1_s;
          op_we_nxt_s     = sel_we_s;
          gnt_nxt_s       = pick1_s ? 2'b10 : 2'b01;
          mem_en_nxt_s    = 1'b1;
          mem_we_nxt_s    = sel_we_s;
          mem_addr_nxt_s  = sel_addr_s;
          mem_wdata_nxt_s = sel_we_s ? sel_wdata_s : {DATA_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_nxt_s  = ST_RESP;
        mem_en_nxt_s = 1'b0;
        mem_we_nxt_s = 1'b0;
      end
      ST_RESP: begin
        // Memory output is valid now, one cycle after the enable cycle.
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = 2'b00;
        if (owner_r) begin
          done_nxt_s = 2'b10;
          if (!op_we_r) begin
            rdata1_nxt_s = mem_rdata;
          end else begin
            rdata1_nxt_s = rdata1_r;
          end
        end else begin
          done_nxt_s = 2'b01;
          if (!op_we_r) begin
            rdata0_nxt_s = mem_rdata;
          end else begin
            rdata0_nxt_s = rdata0_r;
          end
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        gnt_nxt_s    = 2'b00;
        mem_en_nxt_s = 1'b0;
        mem_we_nxt_s = 1'b0;
      end
    endcase
  end

  // Control state: FSM, owner, grants, done pulses and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      owner_r  <= 1'b0;
      op_we_r  <= 1'b0;
      gnt_r    <= 2'b00;
      done_r   <= 2'b00;
      busy_r   <= 1'b0;
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      op_we_r  <= op_we_nxt_s;
      gnt_r    <= gnt_nxt_s;
      done_r   <= done_nxt_s;
      busy_r   <= (state_nxt_s != ST_IDLE);
      mem_en_r <= mem_en_nxt_s;
      mem_we_r <= mem_we_nxt_s;
    end
  end

  // Datapath registers: memory address/data and per-requester read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      rdata0_r    <= {DATA_W{1'b0}};
      rdata1_r    <= {DATA_W{1'b0}};
    end else begin
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      rdata0_r    <= rdata0_nxt_s;
      rdata1_r    <= rdata1_nxt_s;
    end
  end

  assign gnt0      = gnt_r[0];
  assign gnt1      = gnt_r[1];
  assign done0     = done_r[0];
  assign done1     = done_r[1];
  assign rdata0    = rdata0_r;
  assign rdata1    = rdata1_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: random two-requester traffic against a transaction-schedule model of the arbiter,
// plus a reset-during-access scenario. Honours ARB_FIXED_PRIO_EN in the tie rule.
module tb_dmem_port_arbiter;

  localparam int MAXE        = 512;
  localparam int ISSUE_EDGES = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [15:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Requester drive state
  bit          t_req   [2];
  bit          t_we    [2];
  logic [3:0]  t_addr  [2];
  logic [15:0] t_wdata [2];
  bit          act     [2];

  // Memory and its shadow copy
  logic [15:0] mem      [16];
  logic [15:0] seed_val [16];
  logic [15:0] shadow   [16];
  logic        mem_load;

  // Expected-event schedule, indexed by edge number within a phase
  bit          e_gnt   [2][MAXE];
  bit          e_done  [2][MAXE];
  bit          e_rdv   [2][MAXE];
  logic [15:0] e_rdval [2][MAXE];
  bit          e_en    [MAXE];
  bit          e_we    [MAXE];
  logic [3:0]  e_addr  [MAXE];
  logic [15:0] e_wdata [MAXE];

  assign req0   = t_req[0];
  assign req1   = t_req[1];
  assign we0    = t_we[0];
  assign we1    = t_we[1];
  assign addr0  = t_addr[0];
  assign addr1  = t_addr[1];
  assign wdata0 = t_wdata[0];
  assign wdata1 = t_wdata[1];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Synchronous single-port memory: read data appears the cycle after the enable cycle.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= seed_val[i];
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic issue(input int x, input bit force_read);
    t_req[x]   = 1'b1;
    t_we[x]    = force_read ? 1'b0 : 1'($urandom_range(0, 1));
    t_addr[x]  = 4'($urandom_range(0, 15));
    t_wdata[x] = 16'($urandom);
    act[x]     = 1'b1;
  endtask

  // One traffic phase starting right after reset (arbiter idle, rdata zero, requester 0 wins first tie).
  task automatic run_phase();
    int k, nf, ls, w, g;
    bit el0, el1, drained;
    logic [15:0] exp_rd [2];
    for (int i = 0; i < MAXE; i++) begin
      for (int x = 0; x < 2; x++) begin
        e_gnt[x][i] = 1'b0; e_done[x][i] = 1'b0; e_rdv[x][i] = 1'b0; e_rdval[x][i] = 16'h0000;
      end
      e_en[i] = 1'b0; e_we[i] = 1'b0; e_addr[i] = 4'h0; e_wdata[i] = 16'h0000;
    end
    nf = 0; ls = 1; drained = 1'b0;
    exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0000;
    act[0] = 1'b0; act[1] = 1'b0;
    for (k = 0; k < MAXE - 4; k++) begin
      for (int x = 0; x < 2; x++)
        if (e_rdv[x][k]) exp_rd[x] = e_rdval[x][k];
      check("gnt0",   32'(gnt0),   32'(e_gnt[0][k]));
      check("gnt1",   32'(gnt1),   32'(e_gnt[1][k]));
      check("done0",  32'(done0),  32'(e_done[0][k]));
      check("done1",  32'(done1),  32'(e_done[1][k]));
      check("mem_en", 32'(mem_en), 32'(e_en[k]));
      check("mem_we", 32'(mem_we), 32'(e_we[k]));
      check("busy",   32'(busy),   32'(e_gnt[0][k] | e_gnt[1][k]));
      check("rdata0", 32'(rdata0), 32'(exp_rd[0]));
      check("rdata1", 32'(rdata1), 32'(exp_rd[1]));
      if (e_en[k]) begin
        check("mem_addr",  32'(mem_addr),  32'(e_addr[k]));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wdata[k]));
      end
      // Requesters: fields change only at the edge where done is sampled high.
      for (int x = 0; x < 2; x++) begin
        if (act[x] && e_done[x][k]) begin
          if (k < ISSUE_EDGES && $urandom_range(0, 1) == 1) issue(x, 1'b0);
          else begin
            t_req[x] = 1'b0;
            act[x]   = 1'b0;
          end
        end else if (!act[x] && k < ISSUE_EDGES && (k == 0 || $urandom_range(0, 2) == 0)) begin
          issue(x, k == 0);
        end
      end
      if (k >= ISSUE_EDGES && !act[0] && !act[1] && k >= nf) begin
        drained = 1'b1;
        break;
      end
      // Arbitration at the coming edge: port free, requester asking and not showing done.
      if (k + 1 >= nf) begin
        el0 = t_req[0] && !e_done[0][k];
        el1 = t_req[1] && !e_done[1][k];
        if (el0 || el1) begin
`ifdef ARB_FIXED_PRIO_EN
          w = el0 ? 0 : 1;
`else
          w = (el0 && el1) ? (1 - ls) : (el0 ? 0 : 1);
`endif
          g = k + 1;
          e_gnt[w][g]     = 1'b1;
          e_gnt[w][g + 1] = 1'b1;
          e_en[g]         = 1'b1;
          e_we[g]         = t_we[w];
          e_addr[g]       = t_addr[w];
          e_wdata[g]      = t_we[w] ? t_wdata[w] : 16'h0000;
          e_done[w][g + 2] = 1'b1;
          if (t_we[w]) shadow[t_addr[w]] = t_wdata[w];
          else begin
            e_rdv[w][g + 2]   = 1'b1;
            e_rdval[w][g + 2] = shadow[t_addr[w]];
          end
          ls = w;
          nf = g + 3;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("drain_in_budget", 32'(drained), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_load = 1'b1;
    for (int x = 0; x < 2; x++) begin
      t_req[x] = 1'b0; t_we[x] = 1'b0; t_addr[x] = 4'h0; t_wdata[x] = 16'h0000; act[x] = 1'b0;
    end
    for (int i = 0; i < 16; i++) seed_val[i] = 16'($urandom);
    seed_val[3] = 16'h00AA;
    for (int i = 0; i < 16; i++) shadow[i] = seed_val[i];
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_load = 1'b0;
    check("rst_gnt0",      32'(gnt0),      32'd0);
    check("rst_gnt1",      32'(gnt1),      32'd0);
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    rst_n = 1'b1;

    run_phase();

    // Reset asserted during the ACCESS cycle of a read by requester 0.
    t_req[0] = 1'b1; t_we[0] = 1'b0; t_addr[0] = 4'd3;
    @(posedge clk);
    @(negedge clk);
    check("ra_gnt0_before", 32'(gnt0),   32'd1);
    check("ra_en_before",   32'(mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ra_gnt0_async", 32'(gnt0),   32'd0);
    check("ra_en_async",   32'(mem_en), 32'd0);
    check("ra_busy_async", 32'(busy),   32'd0);
    t_req[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      check("ra_no_done0", 32'(done0), 32'd0);
      check("ra_no_gnt0",  32'(gnt0),  32'd0);
    end

    run_phase();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
